// File: rtl/ttl_univ_shift_pkg.sv
// Shared mode encodings and burst FSM states for the universal shift register.
package ttl_univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_BSHR = 3'b110;
  localparam logic [2:0] MODE_BSHL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } burst_state_t;

endpackage

// File: rtl/ttl_shift_burst_ctrl.sv
// Burst-shift sequencer: clamps the requested count, issues one shift strobe
// per enabled edge and produces the BUSY level and one-cycle DONE pulse.
module ttl_shift_burst_ctrl
  import ttl_univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic          shift_stb,
  output logic          shift_dir,
  output logic          run,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  burst_state_t  state, state_nxt;
  logic [CW-1:0] rem, rem_nxt;
  logic [CW-1:0] n_clamp;
  logic          dir, dir_nxt;
  logic          busy_nxt, done_nxt;
  logic          burst_req;

  assign burst_req = start && (mode == MODE_BSHR || mode == MODE_BSHL);
  assign run       = (state == ST_RUN);

  // A zero-count request parks in RUN with rem=0 so DONE lands one edge later
  always_comb begin
    n_clamp   = (cnt > WIDTH_C) ? WIDTH_C : cnt;
    state_nxt = state;
    rem_nxt   = rem;
    dir_nxt   = dir;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    shift_stb = 1'b0;
    shift_dir = dir;
    case (state)
      ST_IDLE: begin
        shift_dir = mode[0];
        if (burst_req) begin
          dir_nxt = mode[0];
          if (n_clamp == '0) begin
            rem_nxt   = '0;
            state_nxt = ST_RUN;
          end else begin
            shift_stb = 1'b1;
            if (n_clamp == ONE_C) begin
              done_nxt = 1'b1;
            end else begin
              busy_nxt  = 1'b1;
              rem_nxt   = n_clamp - ONE_C;
              state_nxt = ST_RUN;
            end
          end
        end
      end
      ST_RUN: begin
        if (rem == '0) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          shift_stb = 1'b1;
          rem_nxt   = rem - ONE_C;
          if (rem == ONE_C) begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      dir   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      rem   <= rem_nxt;
      dir   <= dir_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: rtl/ttl_univ_shift_n.sv
// N-bit universal shift register with rotate, cascade taps and burst shifting.
// Define TTL_PROP_DELAY_EN to add rise/fall delays on the outputs in simulation.
module ttl_univ_shift_n
  import ttl_univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
`ifdef TTL_PROP_DELAY_EN
  ,
  parameter int DELAY_RISE = 12,
  parameter int DELAY_FALL = 15
`endif
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             CE,
  input  logic [2:0]       MODE,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic             QR_OUT,
  output logic             QL_OUT,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] q_r;
  logic             shift_stb, shift_dir, burst_run;
  logic             busy_i, done_i;

  ttl_shift_burst_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clock     (CP),
    .reset     (CR),
    .en        (CE),
    .mode      (MODE),
    .start     (START),
    .cnt       (CNT),
    .shift_stb (shift_stb),
    .shift_dir (shift_dir),
    .run       (burst_run),
    .busy      (busy_i),
    .done      (done_i)
  );

  // Burst strobes win; plain modes only act while no burst owns the register
  always_ff @(posedge CP) begin
    if (CR) begin
      q_r <= '0;
    end else if (CE) begin
      if (shift_stb) begin
        q_r <= shift_dir ? {DSL, q_r[WIDTH-1:1]} : {q_r[WIDTH-2:0], DSR};
      end else if (!burst_run) begin
        case (MODE)
          MODE_SHR:  q_r <= {q_r[WIDTH-2:0], DSR};
          MODE_SHL:  q_r <= {DSL, q_r[WIDTH-1:1]};
          MODE_LOAD: q_r <= D;
          MODE_ROR:  q_r <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          MODE_ROL:  q_r <= {q_r[0], q_r[WIDTH-1:1]};
          default:   q_r <= q_r;
        endcase
      end
    end
  end

`ifdef TTL_PROP_DELAY_EN
  assign #(DELAY_RISE, DELAY_FALL) Q      = q_r;
  assign #(DELAY_RISE, DELAY_FALL) QR_OUT = q_r[WIDTH-1];
  assign #(DELAY_RISE, DELAY_FALL) QL_OUT = q_r[0];
  assign #(DELAY_RISE, DELAY_FALL) BUSY   = busy_i;
  assign #(DELAY_RISE, DELAY_FALL) DONE   = done_i;
`else
  assign Q      = q_r;
  assign QR_OUT = q_r[WIDTH-1];
  assign QL_OUT = q_r[0];
  assign BUSY   = busy_i;
  assign DONE   = done_i;
`endif

endmodule

// File: tb/tb_ttl_univ_shift_n.sv
// Directed bench for ttl_univ_shift_n (WIDTH=8): vector table plus burst
// corner sequences for clock-enable stalls and reset aborts.
module tb_ttl_univ_shift_n;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_BSHR = 3'b110;
  localparam logic [2:0] M_BSHL = 3'b111;

  logic             CP = 1'b0;
  logic             CR, CE, DSR, DSL, START;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] D;
  logic [CW-1:0]    CNT;
  logic [WIDTH-1:0] Q;
  logic             QR_OUT, QL_OUT, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             cr;
    logic             ce;
    logic [2:0]       mode;
    logic             dsr;
    logic             dsl;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t vecs[$];

  ttl_univ_shift_n #(.WIDTH(WIDTH), .CW(CW)) dut (
    .CP     (CP),
    .CR     (CR),
    .CE     (CE),
    .MODE   (MODE),
    .DSR    (DSR),
    .DSL    (DSL),
    .D      (D),
    .START  (START),
    .CNT    (CNT),
    .Q      (Q),
    .QR_OUT (QR_OUT),
    .QL_OUT (QL_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CP = ~CP;

  function automatic vec_t mk(logic cr, logic ce, logic [2:0] mode, logic dsr, logic dsl,
                              logic [WIDTH-1:0] d, logic start, logic [CW-1:0] cnt,
                              logic [WIDTH-1:0] q, logic busy, logic done);
    vec_t v;
    v.cr = cr; v.ce = ce; v.mode = mode; v.dsr = dsr; v.dsl = dsl;
    v.d = d; v.start = start; v.cnt = cnt; v.q = q; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    CR = v.cr; CE = v.ce; MODE = v.mode; DSR = v.dsr; DSL = v.dsl;
    D = v.d; START = v.start; CNT = v.cnt;
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] eq,
                             input logic eb, input logic ed);
    checks++;
    if (Q !== eq || BUSY !== eb || DONE !== ed || QR_OUT !== eq[WIDTH-1] || QL_OUT !== eq[0]) begin
      errors++;
      $display("[TB] FAIL %s: got Q=%h BUSY=%b DONE=%b QR=%b QL=%b, expected Q=%h BUSY=%b DONE=%b",
               name, Q, BUSY, DONE, QR_OUT, QL_OUT, eq, eb, ed);
    end
  endtask

  initial begin
    int edges;
    applyStimulus(mk(1, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));

    // reset and plain modes
    vecs.push_back(mk(1, 1, M_LOAD, 0, 0, 8'hFF, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, M_SHR,  0, 0, 8'h00, 0, 0, 8'h02, 0, 0));
    vecs.push_back(mk(0, 1, M_SHR,  0, 0, 8'h00, 0, 0, 8'h04, 0, 0));
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, M_ROR,  0, 0, 8'h00, 0, 0, 8'h03, 0, 0));
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, M_ROL,  0, 0, 8'h00, 0, 0, 8'hC0, 0, 0));
    vecs.push_back(mk(0, 1, M_SHL,  0, 1, 8'h00, 0, 0, 8'hE0, 0, 0));
    vecs.push_back(mk(0, 0, M_LOAD, 0, 0, 8'h00, 0, 0, 8'hE0, 0, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 1, 1, 8'h00, 0, 0, 8'hE0, 0, 0));
    vecs.push_back(mk(0, 1, M_BSHR, 1, 1, 8'h00, 0, 3, 8'hE0, 0, 0));
    // burst right by 3 from 01 with DSR=1
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'h01, 0, 0, 8'h01, 0, 0));
    vecs.push_back(mk(0, 1, M_BSHR, 1, 0, 8'h00, 1, 3, 8'h03, 1, 0));
    vecs.push_back(mk(0, 1, M_LOAD, 1, 0, 8'hAA, 0, 0, 8'h07, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 1, 0, 8'h00, 0, 0, 8'h0F, 0, 1));
    vecs.push_back(mk(0, 1, M_HOLD, 1, 0, 8'h00, 0, 0, 8'h0F, 0, 0));
    // burst left with CNT=12 clamped to 8
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'hFF, 0, 0, 8'hFF, 0, 0));
    vecs.push_back(mk(0, 1, M_BSHL, 0, 0, 8'h00, 1, 12, 8'h7F, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h3F, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h1F, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h0F, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h07, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h03, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h01, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    // single-shift burst and zero-count burst
    vecs.push_back(mk(0, 1, M_LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0));
    vecs.push_back(mk(0, 1, M_BSHR, 0, 0, 8'h00, 1, 1, 8'h02, 0, 1));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h02, 0, 0));
    vecs.push_back(mk(0, 1, M_BSHR, 1, 1, 8'h00, 1, 0, 8'h02, 0, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 1, 1, 8'h00, 0, 0, 8'h02, 0, 1));
    vecs.push_back(mk(0, 1, M_HOLD, 1, 1, 8'h00, 0, 0, 8'h02, 0, 0));
    // DONE holds while CE is low
    vecs.push_back(mk(0, 1, M_BSHR, 1, 0, 8'h00, 1, 1, 8'h05, 0, 1));
    vecs.push_back(mk(0, 0, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h05, 0, 1));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h05, 0, 0));
    // START held high across DONE: back-to-back bursts
    vecs.push_back(mk(0, 1, M_BSHR, 0, 0, 8'h00, 1, 2, 8'h0A, 1, 0));
    vecs.push_back(mk(0, 1, M_BSHR, 0, 0, 8'h00, 1, 2, 8'h14, 0, 1));
    vecs.push_back(mk(0, 1, M_BSHR, 0, 0, 8'h00, 1, 2, 8'h28, 1, 0));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h50, 0, 1));
    vecs.push_back(mk(0, 1, M_HOLD, 0, 0, 8'h00, 0, 0, 8'h50, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done);
    end

    // CNT=5 burst with CE low for two edges mid-run
    applyStimulus(mk(0, 1, M_LOAD, 0, 0, 8'h01, 0, 0, 8'h00, 0, 0));
    step();
    applyStimulus(mk(0, 1, M_BSHR, 1, 0, 8'h00, 1, 5, 8'h00, 0, 0));
    step();
    checkOutput("ce_stall_first", 8'h03, 1'b1, 1'b0);
    START = 1'b0;
    MODE  = M_HOLD;
    edges = 1;
    while (!DONE && edges < 20) begin
      CE = (edges == 2 || edges == 3) ? 1'b0 : 1'b1;
      step();
      edges++;
      if (edges == 4) checkOutput("ce_stall_frozen", 8'h07, 1'b1, 1'b0);
    end
    CE = 1'b1;
    checks++;
    if (edges != 7) begin
      errors++;
      $display("[TB] FAIL ce_stall_latency: DONE after %0d edges, expected 7", edges);
    end
    checkOutput("ce_stall_done", 8'h3F, 1'b0, 1'b1);
    step();
    checkOutput("ce_stall_pulse", 8'h3F, 1'b0, 1'b0);

    // reset on the 2nd edge of a CNT=4 burst aborts without DONE
    applyStimulus(mk(0, 1, M_LOAD, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    step();
    applyStimulus(mk(0, 1, M_BSHR, 1, 0, 8'h00, 1, 4, 8'h00, 0, 0));
    step();
    checkOutput("abort_first", 8'h01, 1'b1, 1'b0);
    applyStimulus(mk(1, 1, M_HOLD, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    step();
    checkOutput("abort_reset", 8'h00, 1'b0, 1'b0);
    CR = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("abort_quiet%0d", k), 8'h00, 1'b0, 1'b0);
    end
    applyStimulus(mk(0, 1, M_BSHR, 1, 0, 8'h00, 1, 2, 8'h00, 0, 0));
    step();
    checkOutput("abort_restart1", 8'h01, 1'b1, 1'b0);
    START = 1'b0;
    step();
    checkOutput("abort_restart2", 8'h03, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_univ_shift_n.md
Name: ttl_univ_shift_n

Overview:
- Parametrised N-bit universal shift register, successor to the 4-bit bidirectional TTL part used in the arcade board models.
- Adds width parameter, rotate modes, cascade outputs, clock enable and a counted burst-shift engine with BUSY/DONE handshake.
- Sits in rtl/ttl alongside the discrete TTL models; used for video serialisers and sprite line shifters needing multi-bit shifts per pixel slot.

Parameters:
- WIDTH, 8, register width in bits (>=2)
- CW, $clog2(WIDTH+1), width of burst count input
- DELAY_RISE, 12, output rise delay in ns (only with TTL_PROP_DELAY_EN)
- DELAY_FALL, 15, output fall delay in ns (only with TTL_PROP_DELAY_EN)

Ports:
- CP  in  1  clock, rising edge
- CR  in  1  synchronous active-high clear
- CE  in  1  clock enable; low freezes register and FSM
- MODE  in  3  operation select
- DSR  in  1  serial in, shift toward higher index (enters Q[0])
- DSL  in  1  serial in, shift toward lower index (enters Q[WIDTH-1])
- D  in  WIDTH  parallel load data
- START  in  1  burst request (MODE 110/111 only)
- CNT  in  CW  burst shift count
- Q  out  WIDTH  register contents
- QR_OUT  out  1  Q[WIDTH-1], cascade to next stage DSR
- QL_OUT  out  1  Q[0], cascade to next stage DSL
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse at burst completion

Behaviour:
- One clock CP. Reset is synchronous and active-high on CR. CR has priority over CE. On reset: Q=0, BUSY=0, DONE=0, FSM=IDLE, remaining count=0. Power-up initial value is the same.
- All updates occur on rising CP with CE=1. With CE=0, state holds and DONE holds its value.
- MODE in IDLE, one action per enabled edge:
  - 000: hold.
  - 001: shift right, Q <= {Q[W-2:0],DSR}, i.e. Q[0]<=DSR and Q[i]<=Q[i-1].
  - 010: shift left, Q[W-1]<=DSL and Q[i]<=Q[i+1].
  - 011: parallel load, Q<=D.
  - 100: rotate right, Q[0]<=Q[W-1].
  - 101: rotate left, Q[W-1]<=Q[0].
  - 110 / 111: burst right / left; acts as hold unless START=1.
- Burst FSM, states IDLE and RUN:
  - IDLE, START=1, MODE=11x, CNT>0: latch direction and n=min(CNT,WIDTH). First shift happens on this same edge. If n>1, BUSY<=1, rem<=n-1, go to RUN. If n=1, DONE<=1 and stay in IDLE.
  - IDLE, START=1, CNT=0: no shift; DONE<=1 on the next edge; BUSY stays 0.
  - RUN: one shift per enabled edge in the latched direction, sampling DSR/DSL each edge. Decrement rem. When rem reaches 0, go to IDLE with BUSY<=0 and DONE<=1 on that edge.
  - In RUN, MODE, START, CNT and D are ignored.
- DONE is high for exactly one enabled cycle, then clears.
- Total shifts per burst = min(CNT,WIDTH). Latency from START edge to DONE high is n edges.
- START held high across DONE: a new burst is accepted only from IDLE, so back-to-back bursts are allowed on the edge after DONE.
- Reset mid-burst aborts: Q=0, BUSY=0, DONE is not asserted.
- QR_OUT and QL_OUT are combinational from Q.

Optional Feature:
- Macro TTL_PROP_DELAY_EN.
- Defined: Q, QR_OUT, QL_OUT, BUSY and DONE are driven through continuous assigns with #(DELAY_RISE,DELAY_FALL) for simulation timing fidelity.
- Undefined: zero-delay assigns (synthesis/default build). Register behaviour is identical in both cases.

Decomposition:
- Package ttl_univ_shift_pkg holds:
  - MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_BSHR, MODE_BSHL (3-bit constants).
  - FSM state constants ST_IDLE and ST_RUN.
- One sub-module: ttl_shift_burst_ctrl, containing the FSM, remaining counter, count clamp and BUSY/DONE generation. It outputs a shift-strobe and direction to the datapath in the top module.

Test Plan:
- WIDTH=8: CR=1 while D=8'hFF, MODE=011 -> Q=00 after the edge. Release CR, load 8'hA5 -> Q=A5.
- Q=8'h81, MODE=001, DSR=0, two edges -> Q=04. MODE=100 from 8'h81, one edge -> Q=03. MODE=101 from 8'h81, one edge -> Q=C0.
- Q=8'h01, START with MODE=110, CNT=3, DSR=1 -> Q=0F after 3 edges. BUSY high for edges 1-2, DONE pulses on edge 3.
- CNT=12 (clamped to 8), MODE=111, DSL=0, Q=FF -> Q=00 after 8 edges, DONE on the 8th. CNT=0 -> Q unchanged and DONE pulses one edge later.
- Burst CNT=5 with CE low for 2 cycles mid-run -> completion is delayed by 2 cycles. Shift count is still 5, and DONE is one cycle wide.
- Assert CR at the 2nd edge of a CNT=4 burst -> Q=00, BUSY=0, no DONE pulse. The next START is accepted normally.
